// File: rtl/wb_regfile_if.sv
// Write-back result channel from MEM into the register file.
//   wb_valid  MEM presents a result this cycle
//   wb_ready  register file can accept a result this cycle
//   wb_we     result writes a register (0 = bubble)
//   wb_dst    destination register index
//   wb_data   result value
interface wb_regfile_if #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 32
);

  logic          wb_valid;
  logic          wb_ready;
  logic          wb_we;
  logic [AW-1:0] wb_dst;
  logic [DW-1:0] wb_data;

  // MEM side drives the result, register file answers with ready
  modport master (
    output wb_valid,
    output wb_we,
    output wb_dst,
    output wb_data,
    input  wb_ready
  );

  modport slave (
    input  wb_valid,
    input  wb_we,
    input  wb_dst,
    input  wb_data,
    output wb_ready
  );

endinterface

// File: rtl/wb_regfile.sv
// Write-back end of the register file. Owns the GPR array read by decode,
// accepts MEM results over the wb channel, stages each accepted result in a
// one-entry pending register and commits it on the following edge. Two
// combinational read ports see the pending entry first (write-first bypass).
// After reset the array is swept to CLR_VAL before any result is accepted.
//
// Ports
//   clk       clock, all state updates on rising edge
//   rst       synchronous active-high reset, restarts the clear sweep
//   wb        result channel (slave side): valid/ready/we/dst/data
//   rs_addr   read port A address
//   rt_addr   read port B address
//   ra_data   read port A data (combinational)
//   rb_data   read port B data (combinational)
//   busy      clear sweep in progress (also high while rst is held)
//   wr_count  number of committed register writes, wraps
module wb_regfile #(
  parameter int unsigned   DW      = 32,
  parameter int unsigned   AW      = 5,
  parameter logic [DW-1:0] CLR_VAL = '0
) (
  input  logic           clk,
  input  logic           rst,
  wb_regfile_if.slave    wb,
  input  logic [AW-1:0]  rs_addr,
  input  logic [AW-1:0]  rt_addr,
  output logic [DW-1:0]  ra_data,
  output logic [DW-1:0]  rb_data,
  output logic           busy,
  output logic [31:0]    wr_count
);

  localparam int unsigned NREG = 2 ** AW;
  localparam int unsigned CW   = 32;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t          state;
  logic [AW-1:0]   clr_idx;
  logic            busy_q;
  logic            ready_q;

  logic            pend_v;
  logic            pend_we;
  logic [AW-1:0]   pend_dst;
  logic [DW-1:0]   pend_data;

  logic [DW-1:0]   regs [NREG];

  logic            accept;
  logic            pend_commit;
  logic            hit_a;
  logic            hit_b;

  // rst gates the flags directly so the block looks busy for the whole time
  // reset is held, not just from the first reset edge onwards
  assign busy        = busy_q | rst;
  assign wb.wb_ready = ready_q & ~rst;

  assign accept      = wb.wb_valid & wb.wb_ready;
  assign pend_commit = pend_v & pend_we;

  // Sweep / run FSM, pending stage, commit and write counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= CLEAR;
      clr_idx  <= '0;
      busy_q   <= 1'b1;
      ready_q  <= 1'b0;
      pend_v   <= 1'b0;
      pend_we  <= 1'b0;
      wr_count <= '0;
    end else begin
      pend_v <= 1'b0;
      case (state)
        CLEAR: begin
          regs[clr_idx] <= CLR_VAL;
          clr_idx       <= clr_idx + AW'(1);
          if (clr_idx == AW'(NREG - 1)) begin
            state   <= RUN;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        RUN: begin
          if (pend_commit) begin
            regs[pend_dst] <= pend_data;
            wr_count       <= wr_count + CW'(1);
          end
          // Register 0 writes are staged as non-writing so they neither
          // bypass nor count
          if (accept) begin
            pend_v    <= 1'b1;
            pend_we   <= wb.wb_we & (wb.wb_dst != '0);
            pend_dst  <= wb.wb_dst;
            pend_data <= wb.wb_data;
          end
        end
        default: begin
          state <= CLEAR;
        end
      endcase
    end
  end

  assign hit_a = pend_commit & (pend_dst == rs_addr);
  assign hit_b = pend_commit & (pend_dst == rt_addr);

  // Read port A: zero register and busy read as 0, pending entry wins over array
  always_comb begin
    ra_data = '0;
    if (!busy && (rs_addr != '0)) begin
      if (hit_a) begin
        ra_data = pend_data;
      end else begin
        ra_data = regs[rs_addr];
      end
    end
  end

  // Read port B: same rules as port A, fully independent
  always_comb begin
    rb_data = '0;
    if (!busy && (rt_addr != '0)) begin
      if (hit_b) begin
        rb_data = pend_data;
      end else begin
        rb_data = regs[rt_addr];
      end
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed stimulus, a behavioural model of what each
// port must show, a per-cycle compare against that model, and literal checks.
module tb_wb_regfile;

  localparam int unsigned AW   = 5;
  localparam int unsigned DW   = 32;
  localparam int unsigned NREG = 32;

  logic          clk;
  logic          rst;
  logic [AW-1:0] rs_addr;
  logic [AW-1:0] rt_addr;
  logic [DW-1:0] ra_data;
  logic [DW-1:0] rb_data;
  logic          busy;
  logic [31:0]   wr_count;

  wb_regfile_if #(.AW(AW), .DW(DW)) wb ();

  wb_regfile #(.DW(DW), .AW(AW), .CLR_VAL('0)) dut (
    .clk      (clk),
    .rst      (rst),
    .wb       (wb),
    .rs_addr  (rs_addr),
    .rt_addr  (rt_addr),
    .ra_data  (ra_data),
    .rb_data  (rb_data),
    .busy     (busy),
    .wr_count (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Model: visible register contents (a result is visible from the edge that
  // accepts it), sweep cycles remaining, and the committed-write count which
  // lags acceptance by one edge.
  bit          model_on = 1'b0;
  int          sweep_left = 0;
  logic [31:0] mmem [NREG];
  logic [31:0] mcount = '0;
  bit          inc_pend = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      model_on   = 1'b1;
      sweep_left = NREG;
      for (int i = 0; i < NREG; i++) mmem[i] = '0;
      mcount     = '0;
      inc_pend   = 1'b0;
    end else if (model_on) begin
      if (inc_pend) mcount = mcount + 32'd1;
      inc_pend = 1'b0;
      if (sweep_left != 0) begin
        sweep_left = sweep_left - 1;
      end else if (wb.wb_valid) begin
        if (wb.wb_we && (wb.wb_dst != '0)) begin
          mmem[wb.wb_dst] = wb.wb_data;
          inc_pend = 1'b1;
        end
      end
    end
  end

  function automatic logic [31:0] model_read(input logic [AW-1:0] a, input bit b);
    if (b || (a == '0)) return '0;
    return mmem[a];
  endfunction

  bit exp_busy;

  // Per-cycle compare, mid-cycle so inputs and outputs are settled
  always @(negedge clk) begin
    if (model_on) begin
      exp_busy = rst || (sweep_left != 0);
      check("cyc_busy",     32'(busy),        32'(exp_busy));
      check("cyc_ready",    32'(wb.wb_ready), 32'(!exp_busy));
      check("cyc_ra",       ra_data,          model_read(rs_addr, exp_busy));
      check("cyc_rb",       rb_data,          model_read(rt_addr, exp_busy));
      check("cyc_wr_count", wr_count,         mcount);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_busy",  32'(busy),        32'd1);
    check("rst_ready", 32'(wb.wb_ready), 32'd0);
    tick();
    rst = 1'b0;
  endtask

  // Cycles until busy drops, bounded
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && (n < 200)) begin
      tick();
      n++;
    end
    if (n >= 200) check("wait_idle_timeout", 32'(n), 32'd0);
  endtask

  // Present one result and hold it until the edge that accepts it
  task automatic send(input logic we, input logic [AW-1:0] dst, input logic [DW-1:0] data);
    logic acc;
    int   k;
    wb.wb_valid = 1'b1;
    wb.wb_we    = we;
    wb.wb_dst   = dst;
    wb.wb_data  = data;
    acc = 1'b0;
    k   = 0;
    while (!acc && (k < 200)) begin
      acc = wb.wb_ready;
      tick();
      k++;
    end
    if (!acc) check("send_timeout", 32'(k), 32'd0);
    wb.wb_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  int n;

  initial begin
    rst         = 1'b1;
    wb.wb_valid = 1'b0;
    wb.wb_we    = 1'b0;
    wb.wb_dst   = '0;
    wb.wb_data  = '0;
    rs_addr     = '0;
    rt_addr     = '0;

    // Reset and first sweep
    do_reset();
    wait_idle(n);
    check("sweep1_len", 32'(n), 32'd32);
    check("sweep1_ready", 32'(wb.wb_ready), 32'd1);

    // Fill every register with garbage, back-to-back
    for (int i = 1; i < NREG; i++) begin
      wb.wb_valid = 1'b1;
      wb.wb_we    = 1'b1;
      wb.wb_dst   = 5'(i);
      wb.wb_data  = 32'hA5A5_0000 | 32'(i);
      tick();
    end
    wb.wb_valid = 1'b0;
    tick();
    check("preload_count", wr_count, 32'd31);
    rs_addr = 5'd17;
    #1;
    check("preload_r17", ra_data, 32'hA5A5_0011);

    // Reset clears everything written above
    do_reset();
    wait_idle(n);
    check("sweep2_len", 32'(n), 32'd32);
    for (int i = 0; i < NREG; i++) begin
      rs_addr = 5'(i);
      rt_addr = 5'(NREG - 1 - i);
      #1;
      check("clear_ra", ra_data, 32'd0);
      check("clear_rb", rb_data, 32'd0);
      tick();
    end

    // Single write: bypass next cycle, array afterwards
    send(1'b1, 5'd5, 32'hDEAD_BEEF);
    rs_addr = 5'd5;
    #1;
    check("bypass_r5", ra_data, 32'hDEAD_BEEF);
    check("count_pre_commit", wr_count, 32'd0);
    tick();
    check("commit_r5", ra_data, 32'hDEAD_BEEF);
    check("count_one", wr_count, 32'd1);
    tick();
    check("array_r5", ra_data, 32'hDEAD_BEEF);

    // Back-to-back writes to one register
    wb.wb_valid = 1'b1;
    wb.wb_we    = 1'b1;
    wb.wb_dst   = 5'd5;
    wb.wb_data  = 32'h11;
    tick();
    rt_addr = 5'd5;
    #1;
    check("b2b_first_ra", ra_data, 32'h11);
    check("b2b_first_rb", rb_data, 32'h11);
    wb.wb_data = 32'h22;
    tick();
    check("b2b_second", ra_data, 32'h22);
    check("b2b_count_mid", wr_count, 32'd2);
    wb.wb_valid = 1'b0;
    tick();
    check("b2b_count_end", wr_count, 32'd3);
    tick();
    check("b2b_array", ra_data, 32'h22);

    // Register 0 write and bubble leave state alone
    send(1'b1, 5'd7, 32'h77);
    tick();
    check("r7_count", wr_count, 32'd4);
    wb.wb_valid = 1'b1;
    wb.wb_we    = 1'b1;
    wb.wb_dst   = 5'd0;
    wb.wb_data  = 32'hFFFF_FFFF;
    tick();
    rs_addr = 5'd0;
    #1;
    check("r0_bypass", ra_data, 32'd0);
    wb.wb_we   = 1'b0;
    wb.wb_dst  = 5'd7;
    wb.wb_data = 32'h5555_5555;
    tick();
    wb.wb_valid = 1'b0;
    rt_addr = 5'd7;
    #1;
    check("bubble_r7_bypass", rb_data, 32'h77);
    tick();
    tick();
    check("r0_zero", ra_data, 32'd0);
    check("r7_kept", rb_data, 32'h77);
    check("r0_count", wr_count, 32'd4);

    // Reset right after accept drops the pending entry
    send(1'b1, 5'd9, 32'h1234);
    rs_addr = 5'd9;
    #1;
    check("pend_r9", ra_data, 32'h1234);
    rst = 1'b1;
    #1;
    check("rst_read_zero", ra_data, 32'd0);
    tick();
    rst = 1'b0;
    wait_idle(n);
    check("sweep3_len", 32'(n), 32'd32);
    check("dropped_r9", ra_data, 32'd0);
    check("dropped_r7", rb_data, 32'd0);
    check("dropped_count", wr_count, 32'd0);

    // Reset mid-sweep with a result held on the channel throughout
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    wb.wb_valid = 1'b1;
    wb.wb_we    = 1'b1;
    wb.wb_dst   = 5'd3;
    wb.wb_data  = 32'h0000_ABCD;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_idle(n);
    check("sweep4_len", 32'(n), 32'd32);
    rs_addr = 5'd3;
    #1;
    check("held_not_taken", ra_data, 32'd0);
    check("held_ready", 32'(wb.wb_ready), 32'd1);
    tick();
    wb.wb_valid = 1'b0;
    check("held_taken", ra_data, 32'h0000_ABCD);
    tick();
    check("held_count", wr_count, 32'd1);
    tick();
    check("held_array", ra_data, 32'h0000_ABCD);

    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
